// File: rtl/servo_pwm_pkg.sv
// Shared constants for the servo PWM bank: register offsets, control bit
// positions, bus widths and reset defaults (20 ms period, 1.5 ms pulse).
package servo_pwm_pkg;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 32;

  localparam int unsigned ADDR_CTRL   = 0;
  localparam int unsigned ADDR_PERIOD = 1;
  localparam int unsigned ADDR_STATUS = 2;
  localparam int unsigned ADDR_PULSE0 = 4;

  localparam int unsigned CTRL_EN_BIT     = 0;
  localparam int unsigned STATUS_PEND_BIT = 0;

  localparam int unsigned RST_PERIOD = 20000;
  localparam int unsigned RST_PULSE  = 1500;

  // Word address of the PULSE register for channel ch.
  function automatic logic [ADDR_W-1:0] pulse_addr(input int unsigned ch);
    return ADDR_W'(ADDR_PULSE0 + ch);
  endfunction

endpackage

// File: rtl/servo_pwm_bank_if.sv
// Register-bus interface for the servo PWM bank.
//   address    : register word address
//   chipselect : slave select
//   write_n    : active-low write strobe, qualified by chipselect
//   writedata  : write data
//   readdata   : zero-wait-state read data from the slave
interface servo_pwm_bank_if;
  import servo_pwm_pkg::*;

  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );

endinterface

// File: rtl/servo_pwm_channel.sv
// One PWM channel: staging pulse register, active pulse register loaded at
// frame boundaries, and the registered compare output.
//   clk, reset : clock, synchronous active-high reset
//   wr_i       : write strobe for this channel's staging register
//   wdata_i    : staging write value
//   load_i     : copy staging into active this cycle
//   run_i      : frame counter is running (enabled, non-zero period)
//   cnt_i      : current frame count
//   stage_o    : staging value for readback
//   pwm_o      : registered pulse output
module servo_pwm_channel
  import servo_pwm_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_i,
  input  logic [CNT_W-1:0] wdata_i,
  input  logic             load_i,
  input  logic             run_i,
  input  logic [CNT_W-1:0] cnt_i,
  output logic [CNT_W-1:0] stage_o,
  output logic             pwm_o
);

  logic [CNT_W-1:0] stage_q, stage_d;
  logic [CNT_W-1:0] act_q, act_d;
  logic             pwm_q, pwm_d;

  // Next-state: staging takes bus writes, active takes staging on load.
  always_comb begin
    stage_d = stage_q;
    act_d   = act_q;
    pwm_d   = 1'b0;
    if (wr_i)   stage_d = wdata_i;
    if (load_i) act_d   = stage_q;
    pwm_d = run_i & (cnt_i < act_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stage_q <= CNT_W'(RST_PULSE);
      act_q   <= CNT_W'(RST_PULSE);
      pwm_q   <= 1'b0;
    end else begin
      stage_q <= stage_d;
      act_q   <= act_d;
      pwm_q   <= pwm_d;
    end
  end

  assign stage_o = stage_q;
  assign pwm_o   = pwm_q;

endmodule

// File: rtl/servo_pwm_bank.sv
// Bank of NUM_CH servo PWM channels sharing one prescaler and frame counter.
// Period and pulse writes are staged and applied together at the next frame
// boundary so a servo never sees a torn frame.
//   clk, reset  : clock, synchronous active-high reset
//   bus         : register bus (slave side), combinational readdata
//   pwm_out     : registered pulse outputs, one per channel
//   frame_tick  : one-cycle pulse at each frame start
module servo_pwm_bank
  import servo_pwm_pkg::*;
#(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned PRESCALE = 50
) (
  input  logic              clk,
  input  logic              reset,
  servo_pwm_bank_if.slave   bus,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              frame_tick
);

  localparam int unsigned PSC_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

  logic             enable_q, enable_d;
  logic             pending_q, pending_d;
  logic [CNT_W-1:0] period_stg_q, period_stg_d;
  logic [CNT_W-1:0] period_act_q, period_act_d;
  logic [PSC_W-1:0] psc_q, psc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             frame_tick_q, frame_tick_d;

  logic              wr_c, wr_ctrl_c, wr_period_c, wr_stage_c;
  logic [NUM_CH-1:0] wr_pulse_c;
  logic              run_c, tick_c, boundary_c, load_c;
  logic [CNT_W-1:0]  wdata_c;
  logic [CNT_W-1:0]  pulse_stg [NUM_CH];
  logic [DATA_W-1:0] rdata_c;
  logic              unused_wdata;

  // Bus write decode; data bits above CNT_W are dropped.
  assign wr_c        = bus.chipselect & ~bus.write_n;
  assign wr_ctrl_c   = wr_c & (bus.address == ADDR_W'(ADDR_CTRL));
  assign wr_period_c = wr_c & (bus.address == ADDR_W'(ADDR_PERIOD));
  assign wr_stage_c  = wr_period_c | (|wr_pulse_c);
  assign wdata_c     = bus.writedata[CNT_W-1:0];
  assign unused_wdata = ^bus.writedata;

  // Control, timing and staging next-state.
  always_comb begin
    enable_d     = enable_q;
    period_stg_d = period_stg_q;
    if (wr_ctrl_c)   enable_d     = bus.writedata[CTRL_EN_BIT];
    if (wr_period_c) period_stg_d = wdata_c;

    // Counting only while enabled now and staying enabled, so a disable
    // write zeroes counters and outputs on the same edge it lands.
    run_c      = enable_q & enable_d & (period_act_q != '0);
    tick_c     = run_c & (psc_q == PSC_W'(PRESCALE - 1));
    boundary_c = tick_c & (cnt_q == period_act_q - CNT_W'(1));

    // A write landing on the boundary is not yet in staging_q, so it is
    // naturally deferred and keeps pending set below.
    load_c       = ~enable_q | (boundary_c & pending_q);
    period_act_d = load_c ? period_stg_q : period_act_q;

    psc_d = '0;
    if (run_c && !tick_c) psc_d = psc_q + PSC_W'(1);

    cnt_d = '0;
    if (run_c && !boundary_c) cnt_d = tick_c ? cnt_q + CNT_W'(1) : cnt_q;

    pending_d = pending_q;
    if (!enable_q)       pending_d = 1'b0;
    else if (wr_stage_c) pending_d = 1'b1;
    else if (boundary_c) pending_d = 1'b0;

    // Enable rising starts a frame; use the period it will run with.
    frame_tick_d = boundary_c | (~enable_q & enable_d & (period_act_d != '0));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      enable_q     <= 1'b0;
      pending_q    <= 1'b0;
      period_stg_q <= CNT_W'(RST_PERIOD);
      period_act_q <= CNT_W'(RST_PERIOD);
      psc_q        <= '0;
      cnt_q        <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      enable_q     <= enable_d;
      pending_q    <= pending_d;
      period_stg_q <= period_stg_d;
      period_act_q <= period_act_d;
      psc_q        <= psc_d;
      cnt_q        <= cnt_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  // Per-channel staging/active/compare.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign wr_pulse_c[g] = wr_c & (bus.address == pulse_addr(g));

    servo_pwm_channel #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .wr_i    (wr_pulse_c[g]),
      .wdata_i (wdata_c),
      .load_i  (load_c),
      .run_i   (run_c),
      .cnt_i   (cnt_q),
      .stage_o (pulse_stg[g]),
      .pwm_o   (pwm_out[g])
    );
  end

  // Zero-wait-state readback; unmapped addresses read 0.
  always_comb begin
    rdata_c = '0;
    case (bus.address)
      ADDR_W'(ADDR_CTRL):   rdata_c[CTRL_EN_BIT]     = enable_q;
      ADDR_W'(ADDR_PERIOD): rdata_c                  = DATA_W'(period_stg_q);
      ADDR_W'(ADDR_STATUS): rdata_c[STATUS_PEND_BIT] = pending_q;
      default: begin
        for (int unsigned n = 0; n < NUM_CH; n++) begin
          if (bus.address == pulse_addr(n)) rdata_c = DATA_W'(pulse_stg[n]);
        end
      end
    endcase
  end

  assign bus.readdata = rdata_c;
  assign frame_tick   = frame_tick_q;

endmodule

// File: tb/tb_servo_pwm_bank.sv
// Directed bench for servo_pwm_bank with NUM_CH=4, CNT_W=16, PRESCALE=2.
module tb_servo_pwm_bank;

  localparam int unsigned NUM_CH = 4;
  localparam int PER = 10;          // programmed period in counts
  localparam int FRM = 2 * PER;     // frame length in clk cycles

  logic              clk;
  logic              reset;
  logic [NUM_CH-1:0] pwm_out;
  logic              frame_tick;

  servo_pwm_bank_if bus ();

  servo_pwm_bank #(
    .NUM_CH   (NUM_CH),
    .CNT_W    (16),
    .PRESCALE (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .pwm_out    (pwm_out),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int a0     = 0;            // cycle in which the current run's first frame starts
  int wtab [8][NUM_CH];      // pulse width per frame index (relative to a0) per channel
  logic [31:0] rd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    step();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic rdreg(input logic [3:0] a, output logic [31:0] d);
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    #1;
    d = bus.readdata;
    bus.chipselect = 1'b0;
  endtask

  // Expected {frame_tick, pwm_out} in cycle c: the output reflects the count
  // held in the previous cycle; each count lasts two cycles.
  function automatic logic [4:0] exp_out(input int c);
    logic [3:0] p;
    logic       ft;
    int         k, f, cnt;
    p  = '0;
    ft = ((c - a0) % FRM) == 0;
    if (c > a0) begin
      k   = c - 1 - a0;
      f   = k / FRM;
      cnt = (k % FRM) / 2;
      for (int ch = 0; ch < NUM_CH; ch++) p[ch] = (cnt < wtab[f][ch]);
    end
    return {ft, p};
  endfunction

  task automatic run_to(input int target);
    while (cyc < target) begin
      step();
      check($sformatf("frame_out@+%0d", cyc - a0), 32'({frame_tick, pwm_out}),
            32'(exp_out(cyc)));
    end
  endtask

  initial begin
    reset          = 1'b1;
    bus.address    = '0;
    bus.writedata  = '0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    repeat (3) step();
    reset = 1'b0;

    // Reset state
    check("rst_pwm", 32'(pwm_out), 32'h0);
    check("rst_ftick", 32'(frame_tick), 32'h0);
    rdreg(4'd0, rd); check("rst_ctrl", rd, 32'd0);
    rdreg(4'd1, rd); check("rst_period", rd, 32'd20000);
    rdreg(4'd4, rd); check("rst_pulse0", rd, 32'd1500);
    rdreg(4'd2, rd); check("rst_status", rd, 32'd0);

    // Program period 10 / pulse0 3 while disabled, then enable
    wr(4'd1, 32'd10);
    wr(4'd4, 32'd3);
    rdreg(4'd2, rd); check("dis_status", rd, 32'd0);
    for (int f = 0; f < 8; f++) wtab[f] = '{3, 1500, 1500, 1500};
    wr(4'd0, 32'd1);
    a0 = cyc;
    check("en_ftick_pwm", 32'({frame_tick, pwm_out}), 32'h10);
    run_to(a0 + 43);

    // Mid-frame updates: frame 2 keeps old widths, frame 3 takes new ones
    wr(4'd4, 32'd7);
    wr(4'd5, 32'd0);
    wr(4'd6, 32'd10);
    for (int f = 3; f < 8; f++) wtab[f] = '{7, 0, 10, 1500};
    rdreg(4'd2, rd); check("mid_status", rd, 32'd1);
    rdreg(4'd4, rd); check("stage_pulse0", rd, 32'd7);
    run_to(a0 + 61);
    rdreg(4'd2, rd); check("post_bnd_status", rd, 32'd0);

    // Write on the boundary cycle of frame 3 is deferred one frame
    run_to(a0 + 79);
    wr(4'd4, 32'd2);
    for (int f = 5; f < 8; f++) wtab[f] = '{2, 0, 10, 1500};
    rdreg(4'd2, rd); check("bnd_wr_status", rd, 32'd1);
    run_to(a0 + 101);
    rdreg(4'd2, rd); check("bnd_wr_status2", rd, 32'd0);

    // Disable mid-pulse, then re-enable for a full first pulse
    run_to(a0 + 102);
    wr(4'd0, 32'd0);
    check("dis_pwm", 32'({frame_tick, pwm_out}), 32'h0);
    repeat (3) step();
    check("dis_pwm_hold", 32'({frame_tick, pwm_out}), 32'h0);
    rdreg(4'd0, rd); check("dis_ctrl", rd, 32'd0);
    wr(4'd0, 32'd1);
    a0 = cyc;
    for (int f = 0; f < 8; f++) wtab[f] = '{2, 0, 10, 1500};
    check("reen_ftick_pwm", 32'({frame_tick, pwm_out}), 32'h10);
    run_to(a0 + 22);

    // Reset mid-frame with a pending write
    wr(4'd7, 32'd5);
    rdreg(4'd2, rd); check("pre_rst_status", rd, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst_out", 32'({frame_tick, pwm_out}), 32'h0);
    rdreg(4'd1, rd); check("mid_rst_period", rd, 32'd20000);
    for (int n = 0; n < NUM_CH; n++) begin
      rdreg(4'(4 + n), rd); check($sformatf("mid_rst_pulse%0d", n), rd, 32'd1500);
    end
    rdreg(4'd0, rd); check("mid_rst_ctrl", rd, 32'd0);
    rdreg(4'd2, rd); check("mid_rst_status", rd, 32'd0);
    rdreg(4'd3, rd); check("addr3_read", rd, 32'd0);

    // Zero period holds everything idle, even across the enable edge
    wr(4'd1, 32'd0);
    wr(4'd0, 32'd1);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("p0_out%0d", i), 32'({frame_tick, pwm_out}), 32'h0);
      step();
    end

    // Unmapped write ignored; upper write bits dropped
    wr(4'd3, 32'hFFFF_FFFF);
    rdreg(4'd3, rd); check("addr3_wr_ignored", rd, 32'd0);
    wr(4'd1, 32'h0001_000A);
    rdreg(4'd1, rd); check("period_trunc", rd, 32'h0000_000A);
    rdreg(4'd2, rd); check("p0_pending", rd, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
